// File: rtl/sysid_check_master_pkg.sv
// Shared definitions for the system-ID check master: sequencer state encoding,
// sysid register word offsets and the timeout counter sizing helper.
package sysid_check_master_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ID_REQ  = 3'd1;
  localparam logic [2:0] ST_ID_WAIT = 3'd2;
  localparam logic [2:0] ST_TS_REQ  = 3'd3;
  localparam logic [2:0] ST_TS_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam int unsigned SYSID_ID_ADDR = 0;
  localparam int unsigned SYSID_TS_ADDR = 1;

  // Counter must hold TIMEOUT_CYC and never be narrower than 8 bits.
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return ($clog2(cyc + 1) > 8) ? $clog2(cyc + 1) : 8;
  endfunction

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only bus between the check master and the sysid slave.
interface sysid_check_master_if #(
  parameter int unsigned ADDR_W = 1
);
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_waitrequest;
  logic [31:0]       av_readdata;
  logic              av_readdatavalid;

  modport master (
    output av_address, av_read,
    input  av_waitrequest, av_readdata, av_readdatavalid
  );

  modport slave (
    input  av_address, av_read,
    output av_waitrequest, av_readdata, av_readdatavalid
  );
endinterface

// File: rtl/sysid_check_master_avmm_single_read.sv
// One Avalon-MM read: issue, hold under waitrequest, capture data, and abort
// after TIMEOUT_CYC cycles measured from the first av_read cycle.
module avmm_single_read
  import sysid_check_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 1,
  parameter bit          USE_RDV     = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clock,
  input  logic                reset,
  sysid_check_master_if.master av,
  input  logic                issue,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                accept,
  output logic                capture,
  output logic                expire,
  output logic [31:0]         data
);

  localparam int unsigned      CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic              rd_q;
  logic              wait_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              active;

  assign av.av_read    = rd_q;
  assign av.av_address = addr_q;
  assign data          = av.av_readdata;

  assign accept  = rd_q & ~av.av_waitrequest;
  assign capture = USE_RDV ? (wait_q & av.av_readdatavalid) : accept;
  assign active  = rd_q | wait_q;
  // A capture on the expiry cycle takes priority over the timeout.
  assign expire  = active & ~capture & (cnt_q == CNT_LAST);

  // Later assignments override earlier ones: issue beats the accept/capture
  // drop so back-to-back reads keep av_read high without a gap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q   <= 1'b0;
      wait_q <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (active) cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        rd_q   <= 1'b0;
        wait_q <= USE_RDV;
      end
      if (capture || expire) begin
        rd_q   <= 1'b0;
        wait_q <= 1'b0;
      end
      if (issue) begin
        rd_q   <= 1'b1;
        wait_q <= 1'b0;
        addr_q <= issue_addr;
        cnt_q  <= '0;
      end
    end
  end

endmodule

// File: rtl/sysid_check_master.sv
// Reads the sysid ID and timestamp words over Avalon-MM and reports whether
// they match the build-time expected values, or that the sequence timed out.
module sysid_check_master
  import sysid_check_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 1,
  parameter int unsigned ID_ADDR     = SYSID_ID_ADDR,
  parameter int unsigned TS_ADDR     = SYSID_TS_ADDR,
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1457099724,
  parameter bit          USE_RDV     = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  sysid_check_master_if.master av,
  output logic                 busy,
  output logic                 done,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value
);

  logic [2:0]        state_q;
  logic              idle_or_done;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              accept;
  logic              capture;
  logic              expire;
  logic [31:0]       rd_data;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy         = ~idle_or_done;

  always_comb begin
    issue      = 1'b0;
    issue_addr = ADDR_W'(ID_ADDR);
    if (start && idle_or_done) begin
      issue = 1'b1;
    end else if (capture && ((state_q == ST_ID_REQ) || (state_q == ST_ID_WAIT))) begin
      issue      = 1'b1;
      issue_addr = ADDR_W'(TS_ADDR);
    end
  end

  avmm_single_read #(
    .ADDR_W      (ADDR_W),
    .USE_RDV     (USE_RDV),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_read (
    .clock      (clock),
    .reset      (reset),
    .av         (av),
    .issue      (issue),
    .issue_addr (issue_addr),
    .accept     (accept),
    .capture    (capture),
    .expire     (expire),
    .data       (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q  <= ST_ID_REQ;
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
          end
        end
        ST_ID_REQ, ST_ID_WAIT: begin
          if (capture) begin
            id_value <= rd_data;
            state_q  <= ST_TS_REQ;
          end else if (expire) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (accept) begin
            state_q <= ST_ID_WAIT;
          end
        end
        ST_TS_REQ, ST_TS_WAIT: begin
          if (capture) begin
            ts_value <= rd_data;
            id_ok    <= (id_value == EXPECTED_ID);
            ts_ok    <= (rd_data == EXPECTED_TS);
            state_q  <= ST_DONE;
            done     <= 1'b1;
          end else if (expire) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (accept) begin
            state_q <= ST_TS_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: unit 0 samples data on accept, unit 1 uses
// readdatavalid; both share clock/reset and a 16-cycle timeout.
module tb_sysid_check_master;

  localparam int          T      = 16;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1457099724;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        st[2];
  logic        wr[2];
  logic        rv[2];
  logic [31:0] rdat[2];
  logic        rd[2];
  logic [0:0]  adr[2];
  logic        busy[2], done[2], idok[2], tsok[2], tmo[2];
  logic [31:0] idv[2], tsv[2];

  sysid_check_master_if #(.ADDR_W(1)) bus0 ();
  sysid_check_master_if #(.ADDR_W(1)) bus1 ();

  assign bus0.av_waitrequest   = wr[0];
  assign bus0.av_readdata      = rdat[0];
  assign bus0.av_readdatavalid = rv[0];
  assign rd[0]                 = bus0.av_read;
  assign adr[0]                = bus0.av_address;
  assign bus1.av_waitrequest   = wr[1];
  assign bus1.av_readdata      = rdat[1];
  assign bus1.av_readdatavalid = rv[1];
  assign rd[1]                 = bus1.av_read;
  assign adr[1]                = bus1.av_address;

  sysid_check_master #(
    .ADDR_W(1), .ID_ADDR(0), .TS_ADDR(1), .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS), .USE_RDV(1'b0), .TIMEOUT_CYC(T)
  ) dut0 (
    .clock(clock), .reset(reset), .start(st[0]), .av(bus0),
    .busy(busy[0]), .done(done[0]), .id_ok(idok[0]), .ts_ok(tsok[0]),
    .timeout(tmo[0]), .id_value(idv[0]), .ts_value(tsv[0])
  );

  sysid_check_master #(
    .ADDR_W(1), .ID_ADDR(0), .TS_ADDR(1), .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS), .USE_RDV(1'b1), .TIMEOUT_CYC(T)
  ) dut1 (
    .clock(clock), .reset(reset), .start(st[1]), .av(bus1),
    .busy(busy[1]), .done(done[1]), .id_ok(idok[1]), .ts_ok(tsok[1]),
    .timeout(tmo[1]), .id_value(idv[1]), .ts_value(tsv[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          u;
    int          w0, l0;
    logic [31:0] d0;
    int          w1, l1;
    logic [31:0] d1;
    int          xs;
    int          e_done;
    bit          e_to, e_idok, e_tsok;
  } vec_t;

  typedef struct {
    int          done_at;
    bit          to, id_ok, ts_ok;
    logic [31:0] id_v, ts_v;
  } res_t;

  // Each read lasts waits+1 cycles plus the readdatavalid latency; a read
  // longer than T aborts the sequence T cycles after it started.
  function automatic res_t model(input int u, input int w0, input int l0, input logic [31:0] d0,
                                 input int w1, input int l1, input logic [31:0] d1);
    res_t r;
    int dur0 = w0 + 1 + ((u == 1) ? l0 : 0);
    int dur1 = w1 + 1 + ((u == 1) ? l1 : 0);
    r = '{done_at: 0, to: 1'b0, id_ok: 1'b0, ts_ok: 1'b0, id_v: '0, ts_v: '0};
    if (dur0 > T) begin
      r.done_at = 1 + T;
      r.to      = 1'b1;
    end else if (dur1 > T) begin
      r.done_at = 1 + dur0 + T;
      r.to      = 1'b1;
      r.id_v    = d0;
    end else begin
      r.done_at = 1 + dur0 + dur1;
      r.id_v    = d0;
      r.ts_v    = d1;
      r.id_ok   = (d0 == EXP_ID);
      r.ts_ok   = (d1 == EXP_TS);
    end
    return r;
  endfunction

  // Acts as the sysid slave for one sequence and returns what the DUT reported.
  task automatic run_seq(input int u, input int w0, input int l0, input logic [31:0] d0,
                         input int w1, input int l1, input logic [31:0] d1,
                         input int xs, output res_t got);
    int          w[2];
    int          l[2];
    logic [31:0] d[2];
    int          k = 0, wc = 0, pend = 0;
    w[0] = w0; w[1] = w1; l[0] = l0; l[1] = l1; d[0] = d0; d[1] = d1;
    got.done_at = -1;
    @(negedge clock);
    st[u] = 1'b1; wr[u] = 1'b0; rv[u] = 1'b0; rdat[u] = $urandom;
    @(negedge clock);
    st[u] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 1) begin
        chk($sformatf("u%0d cleared done", u), 32'(done[u]), 0);
        chk($sformatf("u%0d cleared timeout", u), 32'(tmo[u]), 0);
        chk($sformatf("u%0d cleared id_value", u), idv[u], 0);
        chk($sformatf("u%0d busy after start", u), 32'(busy[u]), 1);
      end
      if (done[u]) begin
        got.done_at = c;
        break;
      end
      st[u] = (c == xs);
      wr[u] = 1'b0; rv[u] = 1'b0; rdat[u] = $urandom;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rv[u] = 1'b1; rdat[u] = d[k]; k++; wc = 0;
        end
      end
      if (rd[u]) begin
        if (k > 1) begin
          chk($sformatf("u%0d read after both words c%0d", u, c), 1, 0);
        end else begin
          chk($sformatf("u%0d address c%0d", u, c), 32'(adr[u]), k);
          if (wc < w[k]) begin
            wr[u] = 1'b1; wc++;
          end else if (u == 0) begin
            rdat[u] = d[k]; k++; wc = 0;
          end else begin
            pend = l[k];
          end
        end
      end
      @(negedge clock);
    end
    st[u] = 1'b0; wr[u] = 1'b0; rv[u] = 1'b0;
    got.to = tmo[u]; got.id_ok = idok[u]; got.ts_ok = tsok[u];
    got.id_v = idv[u]; got.ts_v = tsv[u];
    chk($sformatf("u%0d busy at done", u), 32'(busy[u]), 0);
  endtask

  task automatic chk_res(input string tag, input res_t g, input res_t e);
    chk({tag, " done cycle"}, g.done_at, e.done_at);
    chk({tag, " timeout"}, 32'(g.to), 32'(e.to));
    chk({tag, " id_ok"}, 32'(g.id_ok), 32'(e.id_ok));
    chk({tag, " ts_ok"}, 32'(g.ts_ok), 32'(e.ts_ok));
    chk({tag, " id_value"}, g.id_v, e.id_v);
    chk({tag, " ts_value"}, g.ts_v, e.ts_v);
  endtask

  vec_t tbl[8];
  res_t got, exp_r;

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; wr[i] = 1'b0; rv[i] = 1'b0; rdat[i] = '0;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset av_read", i), 32'(rd[i]), 0);
      chk($sformatf("u%0d reset busy", i), 32'(busy[i]), 0);
      chk($sformatf("u%0d reset done", i), 32'(done[i]), 0);
      chk($sformatf("u%0d reset flags", i), {29'd0, idok[i], tsok[i], tmo[i]}, 0);
      chk($sformatf("u%0d reset values", i), idv[i] | tsv[i], 0);
    end
    reset = 1'b0;

    tbl = '{
      '{0,  0,  0, EXP_ID, 0,  0, EXP_TS,        0,  3, 1'b0, 1'b1, 1'b1},
      '{0,  5,  0, EXP_ID, 5,  0, EXP_TS,        0, 13, 1'b0, 1'b1, 1'b1},
      '{1,  0,  4, EXP_ID, 0,  4, 32'h12345678,  0, 11, 1'b0, 1'b1, 1'b0},
      '{0, 99,  0, EXP_ID, 0,  0, EXP_TS,        0, 17, 1'b1, 1'b0, 1'b0},
      '{1,  0, 15, EXP_ID, 3, 14, EXP_TS,        0, 33, 1'b1, 1'b0, 1'b0},
      '{0,  2,  0, 32'h5,  1,  0, EXP_TS,        2,  6, 1'b0, 1'b0, 1'b1},
      '{0, 15,  0, EXP_ID, 0,  0, EXP_TS,        0, 18, 1'b0, 1'b1, 1'b1},
      '{1,  0, 16, EXP_ID, 0,  1, EXP_TS,        0, 17, 1'b1, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      run_seq(tbl[i].u, tbl[i].w0, tbl[i].l0, tbl[i].d0,
              tbl[i].w1, tbl[i].l1, tbl[i].d1, tbl[i].xs, got);
      exp_r = model(tbl[i].u, tbl[i].w0, tbl[i].l0, tbl[i].d0, tbl[i].w1, tbl[i].l1, tbl[i].d1);
      exp_r.done_at = tbl[i].e_done;
      exp_r.to      = tbl[i].e_to;
      exp_r.id_ok   = tbl[i].e_idok;
      exp_r.ts_ok   = tbl[i].e_tsok;
      chk_res($sformatf("vec%0d", i), got, exp_r);
    end

    // Reset while unit 0 is held in ID_REQ and unit 1 sits in ID_WAIT.
    @(negedge clock);
    st[0] = 1'b1; st[1] = 1'b1; wr[0] = 1'b1; wr[1] = 1'b1;
    @(negedge clock);
    st[0] = 1'b0; st[1] = 1'b0; wr[1] = 1'b0;
    @(negedge clock);
    chk("pre-reset av_read held", 32'(rd[0]), 1);
    chk("pre-reset u1 busy", 32'(busy[1]), 1);
    reset = 1'b1;
    #1;
    chk("async reset av_read", 32'(rd[0]), 0);
    chk("async reset busy", {30'd0, busy[0], busy[1]}, 0);
    chk("async reset done", {30'd0, done[0], done[1]}, 0);
    chk("async reset id_value", idv[0] | idv[1], 0);
    @(negedge clock);
    reset = 1'b0; wr[0] = 1'b0;
    rv[1] = 1'b1; rdat[1] = 32'hDEADBEEF;
    @(negedge clock);
    rv[1] = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("stray rdv done", 32'(done[1]), 0);
      chk("stray rdv busy", 32'(busy[1]), 0);
      chk("stray rdv id_value", idv[1], 0);
    end

    for (int i = 0; i < 60; i++) begin
      int          u, w0, l0, w1, l1, xs;
      logic [31:0] d0, d1;
      u  = i % 2;
      w0 = ($urandom_range(0, 4) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 6);
      w1 = ($urandom_range(0, 4) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 6);
      l0 = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 17) : $urandom_range(1, 6);
      l1 = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 17) : $urandom_range(1, 6);
      d0 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      d1 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      xs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_seq(u, w0, l0, d0, w1, l1, d1, xs, got);
      chk_res($sformatf("rnd%0d", i), got, model(u, w0, l0, d0, w1, l1, d1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
